dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Multi-cycle data-memory responder on the far side of the CPU MEM-stage load/store interface.
- Accepts one load or store at a time from EX/MEM control and data signals and holds the pipeline with a stall while the access completes.
- Returns read data with a one-cycle acknowledge and flags illegal addresses.
- Word storage is internal; all accesses are 32-bit words.

Parameters:
- DEPTH, 32: number of 32-bit words stored. Must be a power of 2, at least 2.
- LATENCY, 4: BUSY cycles before the access is performed. Must be at least 1.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  reset, synchronous, active-low
- MemRead_i  input  1  load request, from EX/MEM MemRead
- MemWrite_i  input  1  store request, from EX/MEM MemWrite
- Address_i  input  32  byte address, from EX/MEM ALU result
- Writedata_i  input  32  store data, from EX/MEM forwarded RT
- Readdata_o  output  32  load data, registered
- ack_o  output  1  one-cycle completion pulse
- err_o  output  1  address error for the completing access; valid only while ack_o=1
- stall_o  output  1  hold PC, IF/ID, ID/EX and EX/MEM while high

Behaviour:
- Reset: rst_i=0 sampled at a clk_i edge gives state IDLE, Readdata_o=0, ack_o=0, err_o=0, counter=0, all DEPTH words=0. Reset wins over every other event.
- Request: req = MemRead_i | MemWrite_i. If both are high, the access is a store.
- Request hold rule: the requester holds MemRead_i, MemWrite_i, Address_i and Writedata_i stable from acceptance until ack_o. The block latches them on acceptance regardless.
- Index: idx = Address_i[log2(DEPTH)+1:2].
- Address error: Address_i[1:0] != 0, or any bit Address_i[31:log2(DEPTH)+2] set.
- IDLE:
  - stall_o = req, combinational.
  - If req: latch op, idx, error flag and Writedata_i; counter <= LATENCY-1; go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - stall_o=1.
  - If counter != 0: counter decrements.
  - If counter == 0: perform the access on this edge, then go to DONE.
    - Store without error: mem[idx] <= data.
    - Load without error: Readdata_o <= mem[idx].
    - Load with error: Readdata_o <= 0.
    - Store with error: no write, Readdata_o unchanged.
  - err_o <= latched error flag.
- DONE:
  - ack_o=1, stall_o=0 (the pipeline advances on this edge and MEM/WB captures Readdata_o).
  - Inputs are ignored; always return to IDLE.
  - ack_o and err_o return to 0 on the next cycle.
- Timing: request first seen in IDLE at cycle t gives stall_o high for cycles t through t+LATENCY and ack_o at t+LATENCY+1. Minimum spacing between accepted requests is LATENCY+2 cycles.
- Readdata_o holds its value between loads; stores do not change it.
- No request (both low) leaves the block in IDLE with stall_o=0 indefinitely.
- Reset during BUSY or DONE aborts the access: no memory write, no ack_o, stall_o=0 from the next cycle.
- Request inputs changing during BUSY have no effect on the access in flight.

Test Plan:
- Store to 0x0000_0008, data 0xDEADBEEF, issued at t (LATENCY=4) -> stall_o=1 for t..t+4, ack_o=1 only at t+5, err_o=0, Readdata_o stays 0.
- Load from 0x0000_0008 after the previous store -> ack_o at t+5, Readdata_o=0xDEADBEEF from t+5, err_o=0.
- Misaligned store 0x0000_0006, data 0x11111111, then load 0x0000_0004 -> first ack has err_o=1 and no write; the load returns 0x00000000 with err_o=0.
- Load 0x0000_0080 (DEPTH=32) -> ack with err_o=1, Readdata_o=0. Then load 0x0000_007C -> err_o=0.
- Store 0x1234 to 0x0000_000C at t, rst_i=0 at t+2 for 1 cycle -> stall_o=0 at t+3, no ack_o. A subsequent load of 0x0000_000C returns 0.
- MemRead_i=MemWrite_i=1, address 0x0000_0010, data 0xA5A5A5A5 -> treated as a store, Readdata_o unchanged. Then back-to-back loads of 0x10 at t and t+6 -> acks at t+5 and t+11, both 0xA5A5A5A5. Rerun with LATENCY=1 -> ack at t+2.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder
// Multi-cycle data-memory responder for the CPU MEM-stage load/store path.
// One 32-bit word access is accepted at a time. The pipeline is stalled
// while the access is in flight. Completion is signalled by a one-cycle ack,
// which carries the registered read data and an address-error flag.
//
// Ports:
//   clk_i        clock
//   rst_i        synchronous reset, active low
//   MemRead_i    load request
//   MemWrite_i   store request (wins when both request inputs are high)
//   Address_i    byte address (word aligned, below DEPTH*4 to be legal)
//   Writedata_i  store data
//   Readdata_o   registered load data, held between loads
//   ack_o        one-cycle completion pulse
//   err_o        address error of the completing access (valid with ack_o)
//   stall_o      hold the pipeline while high
module dmem_responder #(
  parameter int DEPTH   = 32,
  parameter int LATENCY = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] Address_i,
  input  logic [31:0] Writedata_i,
  output logic [31:0] Readdata_o,
  output logic        ack_o,
  output logic        err_o,
  output logic        stall_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic            write_q, write_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic            addr_err_q, addr_err_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            mem_we;
  logic [31:0]     mem_q [DEPTH];

  logic req;
  logic req_err;

  assign req     = MemRead_i | MemWrite_i;
  // Misaligned, or any address bit above the stored word range set.
  assign req_err = (Address_i[1:0] != 2'b00) | (|Address_i[31:AW+2]);

  always_comb begin
    state_d    = state_q;
    write_d    = write_q;
    idx_d      = idx_q;
    addr_err_d = addr_err_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    mem_we     = 1'b0;
    stall_o    = 1'b0;
    ack_o      = 1'b0;

    case (state_q)
      IDLE: begin
        stall_o = req;
        if (req) begin
          write_d    = MemWrite_i;
          idx_d      = Address_i[AW+1:2];
          addr_err_d = req_err;
          wdata_d    = Writedata_i;
          cnt_d      = CW'(LATENCY - 1);
          state_d    = BUSY;
        end
      end
      BUSY: begin
        stall_o = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          err_d = addr_err_q;
          if (write_q) begin
            // An erroneous store is dropped and leaves Readdata_o untouched.
            mem_we = ~addr_err_q;
          end else begin
            rdata_d = addr_err_q ? 32'h0 : mem_q[idx_q];
          end
          state_d = DONE;
        end
      end
      DONE: begin
        // Pipeline advances on this edge; inputs are not looked at here.
        ack_o   = 1'b1;
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      write_q    <= 1'b0;
      idx_q      <= '0;
      addr_err_q <= 1'b0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      write_q    <= write_d;
      idx_q      <= idx_d;
      addr_err_q <= addr_err_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  // Word storage is cleared by reset, so it is kept as a register array.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign Readdata_o = rdata_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with LATENCY=4 and one
// with LATENCY=1. Expected responses come from a small word-memory model,
// are queued when a request is driven and popped when ack_o is seen.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        rd0, wr0, rd1, wr1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic [31:0] rdata0, rdata1;
  logic        ack0, err0, stall0, ack1, err1, stall1;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(32), .LATENCY(4)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .MemRead_i(rd0), .MemWrite_i(wr0),
    .Address_i(addr0), .Writedata_i(wdata0),
    .Readdata_o(rdata0), .ack_o(ack0), .err_o(err0), .stall_o(stall0)
  );

  dmem_responder #(.DEPTH(32), .LATENCY(1)) dut1 (
    .clk_i(clk), .rst_i(rst_n),
    .MemRead_i(rd1), .MemWrite_i(wr1),
    .Address_i(addr1), .Writedata_i(wdata1),
    .Readdata_o(rdata1), .ack_o(ack1), .err_o(err1), .stall_o(stall1)
  );

  typedef struct {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mmem [2][32];
  logic [31:0] mlast [2];
  int          n_pass = 0;
  int          n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [31:0] rdata_of(input int sel);
    return (sel != 0) ? rdata1 : rdata0;
  endfunction
  function automatic logic ack_of(input int sel);
    return (sel != 0) ? ack1 : ack0;
  endfunction
  function automatic logic err_of(input int sel);
    return (sel != 0) ? err1 : err0;
  endfunction
  function automatic logic stall_of(input int sel);
    return (sel != 0) ? stall1 : stall0;
  endfunction

  task automatic drive(input int sel, input logic rd, input logic wr,
                       input logic [31:0] addr, input logic [31:0] data);
    if (sel != 0) begin
      rd1 = rd; wr1 = wr; addr1 = addr; wdata1 = data;
    end else begin
      rd0 = rd; wr0 = wr; addr0 = addr; wdata0 = data;
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      for (int w = 0; w < 32; w++) mmem[s][w] = 32'h0;
      mlast[s] = 32'h0;
    end
  endtask

  // One complete access: drive at cycle t, check stall through t+LATENCY,
  // then compare the ack cycle and the popped expectation.
  task automatic access(input int sel, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] data,
                        input string tag, input bit perturb);
    int   lat;
    int   k;
    bit   seen;
    bit   aerr;
    exp_t e;
    lat = (sel != 0) ? 1 : 4;
    @(posedge clk); #1;
    check({tag, "_ack_low_before"}, 32'(ack_of(sel)), 32'd0);
    check({tag, "_err_low_before"}, 32'(err_of(sel)), 32'd0);
    drive(sel, rd, wr, addr, data);

    aerr = (addr[1:0] != 2'b00) || (addr[31:7] != 25'd0);
    if (wr) begin
      if (!aerr) mmem[sel][addr[6:2]] = data;
      e.rd = mlast[sel];
    end else begin
      e.rd = aerr ? 32'h0 : mmem[sel][addr[6:2]];
      mlast[sel] = e.rd;
    end
    e.err = aerr;
    sb.push_back(e);

    #1;
    check({tag, "_stall_t"}, 32'(stall_of(sel)), 32'd1);
    seen = 0;
    k = 0;
    while (!seen && k < 20) begin
      @(posedge clk); #1;
      k++;
      if (ack_of(sel)) begin
        seen = 1;
      end else begin
        check({tag, "_stall_busy"}, 32'(stall_of(sel)), 32'd1);
        if (perturb && k == 2) drive(sel, ~rd, ~wr, addr ^ 32'h4, ~data);
      end
    end
    check({tag, "_ack_seen"}, 32'(seen), 32'd1);
    e = sb.pop_front();
    if (seen) begin
      check({tag, "_ack_cycle"}, 32'(k), 32'(lat + 1));
      check({tag, "_stall_done"}, 32'(stall_of(sel)), 32'd0);
      check({tag, "_rdata"}, rdata_of(sel), e.rd);
      check({tag, "_err"}, 32'(err_of(sel)), 32'(e.err));
    end
    drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_rdata", rdata0, 32'h0);
    check("reset_ack", 32'(ack0), 32'd0);
    check("reset_err", 32'(err0), 32'd0);
    check("reset_stall", 32'(stall0), 32'd0);
    check("reset_rdata_l1", rdata1, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("idle_stall", 32'(stall0), 32'd0);
      check("idle_ack", 32'(ack0), 32'd0);
    end

    access(0, 1'b0, 1'b1, 32'h0000_0008, 32'hDEADBEEF, "st_08", 1'b0);
    check("st_08_rdata_zero", rdata0, 32'h0);
    access(0, 1'b1, 1'b0, 32'h0000_0008, 32'h0, "ld_08", 1'b0);
    check("ld_08_value", rdata0, 32'hDEADBEEF);
    access(0, 1'b0, 1'b1, 32'h0000_0006, 32'h11111111, "st_misaligned", 1'b0);
    access(0, 1'b1, 1'b0, 32'h0000_0004, 32'h0, "ld_04", 1'b0);
    access(0, 1'b1, 1'b0, 32'h0000_0080, 32'h0, "ld_80_range", 1'b0);
    access(0, 1'b1, 1'b0, 32'h0000_007C, 32'h0, "ld_7c", 1'b0);
    access(0, 1'b0, 1'b1, 32'h0000_0014, 32'hCAFEF00D, "st_14_perturb", 1'b1);
    access(0, 1'b1, 1'b0, 32'h0000_0014, 32'h0, "ld_14", 1'b0);
    access(0, 1'b1, 1'b0, 32'h0000_0018, 32'h0, "ld_18_untouched", 1'b0);

    // Reset two cycles into a store aborts it.
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b1, 32'h0000_000C, 32'h0000_1234);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    check("abort_stall", 32'(stall0), 32'd0);
    check("abort_ack", 32'(ack0), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("abort_no_ack", 32'(ack0), 32'd0);
    end
    access(0, 1'b1, 1'b0, 32'h0000_000C, 32'h0, "ld_0c_after_abort", 1'b0);

    access(0, 1'b1, 1'b1, 32'h0000_0010, 32'hA5A5A5A5, "both_high", 1'b0);
    access(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0, "ld_10_a", 1'b0);
    access(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0, "ld_10_b", 1'b0);
    check("ld_10_value", rdata0, 32'hA5A5A5A5);

    access(1, 1'b0, 1'b1, 32'h0000_0010, 32'hA5A5A5A5, "l1_st_10", 1'b0);
    access(1, 1'b1, 1'b0, 32'h0000_0010, 32'h0, "l1_ld_10", 1'b0);
    check("l1_ld_10_value", rdata1, 32'hA5A5A5A5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
